cache_ctrl_assoc: RTL
=====================

CACHE_CTRL_ASSOC -- requirements
Module: cache_ctrl_assoc

Interface
REQ-001 SHALL have parameter WAYS, default 2, associativity (1, 2 or 4).
REQ-002 SHALL have parameter SETS, default 256, sets per way (power of two, 2..1024).
REQ-003 SHALL have parameter ADDR_W, default 32, byte-address width.
REQ-004 SHALL have parameter DATA_W, default 32, word width; one word per line.
REQ-005 SHALL use one clock and a synchronous, active-high reset, with ports: clk  in  1  clock; rst  in  1  synchronous active-high reset.
REQ-006 SHALL have ports: cpu_req_addr  in  ADDR_W  byte address; cpu_req_data  in  DATA_W  write data; cpu_req_rw  in  1  0=read, 1=write; cpu_req_valid  in  1  request valid.
REQ-007 SHALL have ports: cpu_res_data  out  DATA_W  read data; cpu_res_ready  out  1  one-cycle completion pulse.
REQ-008 SHALL have ports: mem_req_addr  out  ADDR_W; mem_req_data  out  DATA_W; mem_req_rw  out  1; mem_req_valid  out  1; mem_data  in  DATA_W; mem_ready  in  1.

Function
REQ-009 SHALL decode the address as offset [1:0], index [IDX+1:2] with IDX=log2(SETS), and tag [ADDR_W-1:IDX+2].
REQ-010 SHALL hold per set and way: valid, dirty, tag, data and a log2(WAYS)-bit LRU age.
REQ-011 SHALL implement FSM states IDLE, COMPARE, WRITE_BACK and ALLOCATE.
REQ-012 In IDLE, cpu_req_valid high SHALL latch addr/data/rw at the clock edge and move to COMPARE.
REQ-013 In COMPARE on hit: a read SHALL register the way data to cpu_res_data; a write SHALL update the data and set dirty. cpu_res_ready SHALL pulse high the next cycle, and the FSM SHALL return to IDLE.
REQ-014 Hit latency SHALL be two cycles: valid in cycle 0, ready in cycle 2. A valid sampled in cycle 2 SHALL be accepted as a new request.
REQ-015 On hit, the accessed way's age SHALL be set to 0, ways with a smaller age SHALL be incremented, and the rest SHALL be unchanged.
REQ-016 On miss, the victim SHALL be the lowest-numbered invalid way; otherwise it SHALL be the way with the maximum age.
REQ-017 On miss, the FSM SHALL go to WRITE_BACK if the victim is valid and dirty; otherwise it SHALL go to ALLOCATE.
REQ-018 In WRITE_BACK, the block SHALL drive mem_req_valid=1, rw=1, addr={victim tag, index, 2'b00}, data=victim data, and SHALL move to ALLOCATE on mem_ready.
REQ-019 In ALLOCATE, the block SHALL drive mem_req_valid=1, rw=0, addr={req addr[ADDR_W-1:2], 2'b00}. On mem_ready it SHALL write mem_data into the victim with valid=1, dirty=0 and the new tag, then return to COMPARE, which then hits.
REQ-020 mem_req_* SHALL stay stable while mem_req_valid is high and mem_ready is low; mem_ready SHALL be ignored when mem_req_valid is low.
REQ-021 cpu_req_valid SHALL be ignored outside IDLE.
REQ-022 WAYS=1 SHALL degenerate to direct-mapped, with no age storage and way 0 always the victim.

Reset
REQ-023 Reset SHALL clear all valid and dirty bits, set way w age to w, and return the FSM to IDLE.
REQ-024 On reset, cpu_res_ready, mem_req_valid, mem_req_rw SHALL be 0; cpu_res_data, mem_req_addr, mem_req_data SHALL be 0.
REQ-025 Reset SHALL abort any in-flight miss: mem_req_valid is low the cycle after reset, and a partial line fill SHALL NOT be written.
REQ-026 Tag and data arrays SHALL NOT require reset.

Configuration
REQ-027 With CACHE_STATS_EN defined, the block SHALL add 32-bit wrapping output counters hit_count, miss_count and wb_count. Each counter increments once per hit, per miss entering WRITE_BACK/ALLOCATE, and per completed write-back respectively, and is cleared by reset.
REQ-028 Without CACHE_STATS_EN, these ports and counters SHALL be absent and behaviour SHALL otherwise be identical.

Verification (WAYS=2, SETS=256)
REQ-029 After reset, read 0x100 -> mem read at 0x100; mem returns 0xDEADBEEF with mem_ready after 3 cycles -> cpu_res_data=0xDEADBEEF. A repeat read of 0x100 -> ready 2 cycles after valid, no mem_req_valid.
REQ-030 Read 0x100, read 0x500, write 0x100=0x11223344, read 0x900 -> evicts 0x500 without write-back. Then read 0xD00 -> write-back addr 0x100 data 0x11223344, then read at 0xD00.
REQ-031 Hold mem_ready low 10 cycles during ALLOCATE -> mem_req_addr/rw/valid constant for all 10 cycles, and cpu_res_ready stays low.
REQ-032 Assert rst in the second ALLOCATE cycle -> mem_req_valid=0 the next cycle; a subsequent read of the same address misses.
REQ-033 With CACHE_STATS_EN, the REQ-030 sequence plus a re-read of 0xD00 -> hit_count=2, miss_count=4, wb_count=1.

Source files
------------

// File: rtl/cache_ctrl_assoc.sv
// cache_ctrl_assoc: set-associative write-back cache controller, one word per line, LRU-age replacement.
// Optional statistics counters are enabled by defining CACHE_STATS_EN.
module cache_ctrl_assoc #(
    parameter int WAYS   = 2,
    parameter int SETS   = 256,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] cpu_req_addr,
    input  logic [DATA_W-1:0] cpu_req_data,
    input  logic              cpu_req_rw,
    input  logic              cpu_req_valid,
    output logic [DATA_W-1:0] cpu_res_data,
    output logic              cpu_res_ready,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic [DATA_W-1:0] mem_req_data,
    output logic              mem_req_rw,
    output logic              mem_req_valid,
    input  logic [DATA_W-1:0] mem_data,
    input  logic              mem_ready
`ifdef CACHE_STATS_EN
    ,
    output logic [31:0]       hit_count,
    output logic [31:0]       miss_count,
    output logic [31:0]       wb_count
`endif
);
    localparam int IDX   = $clog2(SETS);
    localparam int TAG_W = ADDR_W - 2 - IDX;
    localparam int WW    = WAYS > 1 ? $clog2(WAYS) : 1;

    typedef enum logic [1:0] {IDLE, COMPARE, WRITE_BACK, ALLOCATE} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-3:0]   req_addr_q, req_addr_d;
    logic [DATA_W-1:0]   req_data_q, req_data_d;
    logic                req_rw_q, req_rw_d;
    logic [WW-1:0]       victim_q, victim_d;
    logic                fill_q, fill_d;
    logic [DATA_W-1:0]   res_data_q, res_data_d;
    logic                res_ready_q, res_ready_d;
    logic                valid_q [WAYS][SETS];
    logic                valid_d [WAYS][SETS];
    logic                dirty_q [WAYS][SETS];
    logic                dirty_d [WAYS][SETS];
    logic [TAG_W-1:0]    tag_q   [WAYS][SETS];
    logic [TAG_W-1:0]    tag_d   [WAYS][SETS];
    logic [DATA_W-1:0]   data_q  [WAYS][SETS];
    logic [DATA_W-1:0]   data_d  [WAYS][SETS];
    logic [IDX-1:0]      idx;
    logic [TAG_W-1:0]    tag;
    logic                hit;
    logic [WW-1:0]       hit_way;
    logic [WW-1:0]       vic_way;
    logic                unused;

    assign idx           = req_addr_q[IDX-1:0];
    assign tag           = req_addr_q[ADDR_W-3:IDX];
    assign cpu_res_data  = res_data_q;
    assign cpu_res_ready = res_ready_q;
    assign unused        = ^cpu_req_addr[1:0];

    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int w = 0; w < WAYS; w++)
            if (valid_q[w][idx] && tag_q[w][idx] == tag) begin
                hit     = 1'b1;
                hit_way = WW'(w);
            end
    end

    // Ages form a permutation of 0..WAYS-1, so the oldest way is the one at WAYS-1.
    if (WAYS > 1) begin : g_lru
        logic [WW-1:0] age_q [WAYS][SETS];
        logic [WW-1:0] age_d [WAYS][SETS];
        always_comb begin
            age_d = age_q;
            if (state_q == COMPARE && hit)
                for (int w = 0; w < WAYS; w++)
                    age_d[w][idx] = WW'(w) == hit_way ? '0 :
                                    age_q[w][idx] < age_q[hit_way][idx] ? age_q[w][idx] + WW'(1) : age_q[w][idx];
        end
        always_comb begin
            vic_way = '0;
            for (int w = 0; w < WAYS; w++)
                if (age_q[w][idx] == WW'(WAYS - 1)) vic_way = WW'(w);
            for (int w = WAYS - 1; w >= 0; w--)
                if (!valid_q[w][idx]) vic_way = WW'(w);
        end
        always_ff @(posedge clk) begin
            if (rst) begin
                for (int w = 0; w < WAYS; w++)
                    for (int s = 0; s < SETS; s++)
                        age_q[w][s] <= WW'(w);
            end else begin
                age_q <= age_d;
            end
        end
    end else begin : g_dm
        assign vic_way = '0;
    end

    always_comb begin
        mem_req_valid = state_q == WRITE_BACK || state_q == ALLOCATE;
        mem_req_rw    = state_q == WRITE_BACK;
        mem_req_addr  = state_q == WRITE_BACK ? {tag_q[victim_q][idx], idx, 2'b00} :
                        state_q == ALLOCATE   ? {req_addr_q, 2'b00} : '0;
        mem_req_data  = state_q == WRITE_BACK ? data_q[victim_q][idx] : '0;
    end

    always_comb begin
        state_d     = state_q;
        req_addr_d  = req_addr_q;
        req_data_d  = req_data_q;
        req_rw_d    = req_rw_q;
        victim_d    = victim_q;
        fill_d      = fill_q;
        res_data_d  = res_data_q;
        res_ready_d = 1'b0;
        valid_d     = valid_q;
        dirty_d     = dirty_q;
        tag_d       = tag_q;
        data_d      = data_q;
        case (state_q)
            IDLE: if (cpu_req_valid) begin
                req_addr_d = cpu_req_addr[ADDR_W-1:2];
                req_data_d = cpu_req_data;
                req_rw_d   = cpu_req_rw;
                state_d    = COMPARE;
            end
            COMPARE: if (hit) begin
                res_ready_d = 1'b1;
                fill_d      = 1'b0;
                state_d     = IDLE;
                if (req_rw_q) begin
                    data_d[hit_way][idx]  = req_data_q;
                    dirty_d[hit_way][idx] = 1'b1;
                end else begin
                    res_data_d = data_q[hit_way][idx];
                end
            end else begin
                victim_d = vic_way;
                state_d  = valid_q[vic_way][idx] && dirty_q[vic_way][idx] ? WRITE_BACK : ALLOCATE;
            end
            WRITE_BACK: if (mem_ready) state_d = ALLOCATE;
            ALLOCATE: if (mem_ready) begin
                valid_d[victim_q][idx] = 1'b1;
                dirty_d[victim_q][idx] = 1'b0;
                tag_d[victim_q][idx]   = tag;
                data_d[victim_q][idx]  = mem_data;
                fill_d                 = 1'b1;
                state_d                = COMPARE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            fill_q      <= 1'b0;
            res_data_q  <= '0;
            res_ready_q <= 1'b0;
            valid_q     <= '{default: '0};
            dirty_q     <= '{default: '0};
        end else begin
            state_q     <= state_d;
            fill_q      <= fill_d;
            res_data_q  <= res_data_d;
            res_ready_q <= res_ready_d;
            valid_q     <= valid_d;
            dirty_q     <= dirty_d;
        end
    end

    // Array writes are blocked during reset so an aborted fill leaves no trace.
    always_ff @(posedge clk) begin
        if (!rst) begin
            req_addr_q <= req_addr_d;
            req_data_q <= req_data_d;
            req_rw_q   <= req_rw_d;
            victim_q   <= victim_d;
            tag_q      <= tag_d;
            data_q     <= data_d;
        end
    end

`ifdef CACHE_STATS_EN
    logic [31:0] hit_count_q, hit_count_d;
    logic [31:0] miss_count_q, miss_count_d;
    logic [31:0] wb_count_q, wb_count_d;

    // The hit that completes a refill is not a fresh hit.
    always_comb begin
        hit_count_d  = hit_count_q + 32'(state_q == COMPARE && hit && !fill_q);
        miss_count_d = miss_count_q + 32'(state_q == COMPARE && !hit);
        wb_count_d   = wb_count_q + 32'(state_q == WRITE_BACK && mem_ready);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hit_count_q  <= '0;
            miss_count_q <= '0;
            wb_count_q   <= '0;
        end else begin
            hit_count_q  <= hit_count_d;
            miss_count_q <= miss_count_d;
            wb_count_q   <= wb_count_d;
        end
    end

    assign hit_count  = hit_count_q;
    assign miss_count = miss_count_q;
    assign wb_count   = wb_count_q;
`endif
endmodule
